// File: rtl/gcf_seq.sv
// ============================================================================
// Module   : gcf_seq
// Function : Multi-cycle binary (Stein) greatest-common-factor engine with
//            valid/ready handshakes on both sides. Optional iteration counter
//            enabled by defining GCF_ITER_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcf_seq #(
    parameter int N  = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef GCF_ITER_COUNT_EN
    output logic [CW-1:0] iter_cnt,
`endif
    output logic [N-1:0]  res
);

    localparam int KW = $clog2(N) + 1;
    localparam logic [KW-1:0] c_K_ONE = KW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_x;
    logic [N-1:0]  r_y;
    logic [KW-1:0] r_k;
    logic [N-1:0]  r_res;
    logic          r_in_ready;
    logic          r_out_valid;

    logic          w_accept;
    logic          w_zero_op;

    assign w_accept  = in_valid && r_in_ready;
    assign w_zero_op = (a == '0) || (b == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_k         <= '0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x        <= a;
                        r_y        <= b;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        // gcf(0,n)=n and gcf(0,0)=0 both reduce to a|b
                        if (w_zero_op) begin
                            r_res       <= a | b;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (!r_x[0] && !r_y[0]) begin
                        r_x <= r_x >> 1;
                        r_y <= r_y >> 1;
                        r_k <= r_k + c_K_ONE;
                    end else begin
                        r_state <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    if (r_x == r_y) begin
                        r_res       <= r_x << r_k;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (!r_x[0]) begin
                        r_x <= r_x >> 1;
                    end else if (!r_y[0]) begin
                        r_y <= r_y >> 1;
                    end else if (r_x > r_y) begin
                        r_x <= (r_x - r_y) >> 1;
                    end else begin
                        r_y <= (r_y - r_x) >> 1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef GCF_ITER_COUNT_EN
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);

    logic [CW-1:0] r_iter_cnt;

    // Saturating count of SHIFT/REDUCE cycles; held with res until next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter_cnt <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_iter_cnt <= '0;
        end else if ((r_state == S_SHIFT || r_state == S_REDUCE) && (r_iter_cnt != '1)) begin
            r_iter_cnt <= r_iter_cnt + c_CNT_ONE;
        end
    end

    assign iter_cnt = r_iter_cnt;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign res       = r_res;

endmodule

`default_nettype wire
